sort_step_ctrl: RTL and testbench
=================================

SORT_STEP_CTRL -- requirements
Module: sort_step_ctrl

Interface
REQ-001 The block SHALL take parameter DEBOUNCE_CYCLES, default 1_000_000: consecutive stable cycles needed to accept a button level.
REQ-002 The block SHALL take parameter STEP_PERIOD, default 100_000_000: cycles between auto-run step pulses.
REQ-003 The block SHALL take parameter CNT_W, default 8: width of step_count.
REQ-004 The block SHALL have port clk, input, 1: system clock, 100 MHz.
REQ-005 The block SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-006 The block SHALL have port btnC, input, 1: run/pause toggle button, asynchronous and bouncy.
REQ-007 The block SHALL have port btnR, input, 1: next-step button, asynchronous.
REQ-008 The block SHALL have port btnL, input, 1: previous-step button, asynchronous.
REQ-009 The block SHALL have port sort_done, input, 1: level from the sorter; array fully sorted.
REQ-010 The block SHALL have port step_fwd, output, 1: one-cycle pulse; sorter performs one compare/swap step.
REQ-011 The block SHALL have port step_back, output, 1: one-cycle pulse; sorter undoes its last step.
REQ-012 The block SHALL have port running, output, 1: high in state RUN.
REQ-013 The block SHALL have port step_count, output, CNT_W: net forward steps taken.

Function
REQ-014 Each button SHALL pass through a 2-FF synchronizer, then a debouncer whose counter restarts on any change of the synchronized level.
REQ-015 Each debouncer SHALL accept the new level after DEBOUNCE_CYCLES stable cycles, and SHALL emit exactly one press pulse per accepted 0->1 transition.
REQ-016 Latency from a clean button rising edge to the resulting step_fwd/step_back pulse or state change SHALL be DEBOUNCE_CYCLES+3 cycles.
REQ-017 The FSM SHALL have states PAUSED, RUN and DONE.
REQ-018 PAUSED + btnC press with sort_done=0 SHALL go to RUN and clear the step timer.
REQ-019 RUN + btnC press SHALL go to PAUSED.
REQ-020 RUN SHALL go to DONE when sort_done=1.
REQ-021 DONE + btnL press SHALL go to PAUSED.
REQ-022 In RUN, the step timer SHALL count 0..STEP_PERIOD-1 and pulse step_fwd on the terminal count, then wrap to 0.
REQ-023 btnR in PAUSED SHALL pulse step_fwd once when sort_done=0 and step_count is below its maximum; otherwise btnR SHALL be ignored.
REQ-024 btnL in PAUSED or DONE SHALL pulse step_back once when step_count>0; otherwise btnL SHALL be ignored.
REQ-025 btnR and btnL SHALL be ignored in RUN.
REQ-026 btnC SHALL be ignored in DONE.
REQ-027 Simultaneous press pulses SHALL be resolved by priority C > R > L, with at most one action per cycle; lower-priority presses in that cycle SHALL be dropped.
REQ-028 step_fwd and step_back SHALL never be high in the same cycle.
REQ-029 step_count SHALL increment on step_fwd and decrement on step_back, and SHALL never wrap.
REQ-030 When step_count reaches 2^CNT_W-1 in RUN, the FSM SHALL go to PAUSED and suppress that step.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 With reset_n=0 at a clk edge: state=PAUSED, step_count=0, step_fwd=0, step_back=0, running=0, timer=0, and debouncers accept level 0.
REQ-033 Reset mid-press SHALL discard the press; a button held through reset release SHALL produce no pulse until it is released and pressed again.

Configuration
REQ-034 With STEP_CTRL_SPEED_EN defined, input speed[1:0] SHALL be present and the auto-run period SHALL be STEP_PERIOD>>(2*speed).
REQ-035 A speed change SHALL take effect at the next timer wrap.
REQ-036 Without STEP_CTRL_SPEED_EN, the speed port SHALL be absent and the period SHALL be fixed at STEP_PERIOD.

Verification (DEBOUNCE_CYCLES=4, STEP_PERIOD=10)
REQ-037 Clean btnR press in PAUSED -> one step_fwd 7 cycles after the edge; step_count=1.
REQ-038 btnR bouncing 0/1 every 2 cycles for 20 cycles, then high -> exactly one step_fwd, issued 7 cycles after the final edge.
REQ-039 btnC press -> running=1, step_fwd every 10 cycles; sort_done=1 -> DONE, no further pulses; btnC is ignored.
REQ-040 btnL press with step_count=0 -> no step_back; after 3 forward steps, 3 btnL presses -> 3 step_back pulses and step_count=0.
REQ-041 btnC and btnR debounced in the same cycle in PAUSED -> RUN entered, no extra step_fwd.
REQ-042 reset_n=0 while RUN with step_count=5 -> next cycle PAUSED, step_count=0, all pulses low.

Source files
------------

// File: rtl/sort_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sort_step_ctrl
// Brief    : Button-driven run/pause/step controller for a step-wise sorter.
//            Optional STEP_CTRL_SPEED_EN adds speed[1:0] to scale the auto-run period.
// Revision : 1.0 - initial release
// ============================================================================
module sort_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int STEP_PERIOD     = 100_000_000,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             btnC,
    input  logic             btnR,
    input  logic             btnL,
    input  logic             sort_done,
`ifdef STEP_CTRL_SPEED_EN
    input  logic [1:0]       speed,
`endif
    output logic             step_fwd,
    output logic             step_back,
    output logic             running,
    output logic [CNT_W-1:0] step_count
);

    localparam int c_DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_TMR_W = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
    localparam logic [c_DB_W-1:0]  c_DB_LAST  = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(STEP_PERIOD - 1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_PAUSED = 2'd0,
        S_RUN    = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    logic [2:0] w_btn_raw;
    logic [2:0] w_press;
    logic       w_press_c;
    logic       w_press_r;
    logic       w_press_l;

    assign w_btn_raw = {btnC, btnR, btnL};
    assign w_press_c = w_press[2];
    assign w_press_r = w_press[1];
    assign w_press_l = w_press[0];

    for (genvar g = 0; g < 3; g++) begin : g_btn
        logic              r_meta;
        logic              r_sync;
        logic              r_level;
        logic              r_armed;
        logic              r_press;
        logic [c_DB_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            r_meta <= w_btn_raw[g];
            r_sync <= r_meta;
        end

        // r_armed blocks the first press after reset until a low level has
        // been seen, so a button held through reset never fires.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_level <= 1'b0;
                r_armed <= 1'b0;
                r_press <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_press <= 1'b0;
                if (!r_sync) begin
                    r_armed <= 1'b1;
                end
                if (r_sync == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_LAST) begin
                    r_cnt   <= '0;
                    r_level <= r_sync;
                    r_press <= r_sync & r_armed;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_press[g] = r_press;
    end

    state_t             r_state;
    logic [c_TMR_W-1:0] r_timer;
    logic [c_TMR_W-1:0] w_tmr_last;
    logic               w_tmr_hit;

    assign w_tmr_hit = (r_timer == w_tmr_last);

`ifdef STEP_CTRL_SPEED_EN
    logic [c_TMR_W-1:0] r_tmr_last;
    logic [31:0]        w_period;

    always_comb begin
        w_period = 32'(STEP_PERIOD) >> {speed, 1'b0};
        if (w_period == 32'd0) begin
            w_period = 32'd1;
        end
    end

    // Outside RUN the period tracks speed freely; inside RUN only at a wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tmr_last <= c_TMR_LAST;
        end else if (r_state != S_RUN || w_tmr_hit) begin
            r_tmr_last <= c_TMR_W'(w_period - 32'd1);
        end
    end

    assign w_tmr_last = r_tmr_last;
`else
    assign w_tmr_last = c_TMR_LAST;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_PAUSED;
            r_timer    <= '0;
            step_count <= '0;
            step_fwd   <= 1'b0;
            step_back  <= 1'b0;
            running    <= 1'b0;
        end else begin
            step_fwd  <= 1'b0;
            step_back <= 1'b0;
            case (r_state)
                S_PAUSED: begin
                    if (w_press_c) begin
                        if (!sort_done) begin
                            r_state <= S_RUN;
                            r_timer <= '0;
                            running <= 1'b1;
                        end
                    end else if (w_press_r) begin
                        if (!sort_done && step_count != c_CNT_MAX) begin
                            step_fwd   <= 1'b1;
                            step_count <= step_count + 1'b1;
                        end
                    end else if (w_press_l && step_count != '0) begin
                        step_back  <= 1'b1;
                        step_count <= step_count - 1'b1;
                    end
                end
                S_RUN: begin
                    if (sort_done) begin
                        r_state <= S_DONE;
                        running <= 1'b0;
                    end else if (w_press_c) begin
                        r_state <= S_PAUSED;
                        running <= 1'b0;
                    end else if (w_tmr_hit) begin
                        r_timer <= '0;
                        if (step_count == c_CNT_MAX) begin
                            r_state <= S_PAUSED;
                            running <= 1'b0;
                        end else begin
                            step_fwd   <= 1'b1;
                            step_count <= step_count + 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!w_press_c && !w_press_r && w_press_l) begin
                        r_state <= S_PAUSED;
                        if (step_count != '0) begin
                            step_back  <= 1'b1;
                            step_count <= step_count - 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_PAUSED;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sort_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sort_step_ctrl
// Brief    : Directed self-checking bench for sort_step_ctrl (DEBOUNCE=4, PERIOD=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sort_step_ctrl;

    localparam int c_DB = 4;
    localparam int c_SP = 10;
    localparam int c_CW = 4;

    logic            clk       = 1'b0;
    logic            reset_n   = 1'b0;
    logic            btnC      = 1'b0;
    logic            btnR      = 1'b0;
    logic            btnL      = 1'b0;
    logic            sort_done = 1'b0;
    logic            step_fwd;
    logic            step_back;
    logic            running;
    logic [c_CW-1:0] step_count;
`ifdef STEP_CTRL_SPEED_EN
    logic [1:0]      speed     = 2'd0;
`endif

    always #5 clk = ~clk;

    sort_step_ctrl #(
        .DEBOUNCE_CYCLES(c_DB),
        .STEP_PERIOD    (c_SP),
        .CNT_W          (c_CW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btnC      (btnC),
        .btnR      (btnR),
        .btnL      (btnL),
        .sort_done (sort_done),
`ifdef STEP_CTRL_SPEED_EN
        .speed     (speed),
`endif
        .step_fwd  (step_fwd),
        .step_back (step_back),
        .running   (running),
        .step_count(step_count)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_fwd   = 0;
    int n_back  = 0;
    int n_both  = 0;

    always @(negedge clk) begin
        if (step_fwd)  n_fwd++;
        if (step_back) n_back++;
        if (step_fwd && step_back) n_both++;
    end

    typedef struct {
        logic [2:0] btn;      // {C, R, L}
        logic       sd;
        int         d_fwd;
        int         d_back;
        int         cnt;
        logic       run;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [2:0] b);
        {btnC, btnR, btnL} = b;
        tick(8);
        {btnC, btnR, btnL} = 3'b000;
        tick(10);
    endtask

    task automatic wait_running(input logic lvl, input int max_t, output int t);
        t = -1;
        for (int k = 1; k <= max_t; k++) begin
            tick(1);
            if (running == lvl) begin
                t = k;
                break;
            end
        end
    endtask

    task automatic wait_fwd(input int max_t, output int t);
        t = -1;
        for (int k = 1; k <= max_t; k++) begin
            tick(1);
            if (step_fwd) begin
                t = k;
                break;
            end
        end
    endtask

    initial begin
        int f0, b0, t;
        int p[3];
        int np;

        vecs[0]  = '{3'b001, 1'b0, 0, 0, 0, 1'b0};
        vecs[1]  = '{3'b010, 1'b0, 1, 0, 1, 1'b0};
        vecs[2]  = '{3'b010, 1'b0, 1, 0, 2, 1'b0};
        vecs[3]  = '{3'b010, 1'b0, 1, 0, 3, 1'b0};
        vecs[4]  = '{3'b001, 1'b0, 0, 1, 2, 1'b0};
        vecs[5]  = '{3'b001, 1'b0, 0, 1, 1, 1'b0};
        vecs[6]  = '{3'b001, 1'b0, 0, 1, 0, 1'b0};
        vecs[7]  = '{3'b001, 1'b0, 0, 0, 0, 1'b0};
        vecs[8]  = '{3'b010, 1'b1, 0, 0, 0, 1'b0};
        vecs[9]  = '{3'b100, 1'b1, 0, 0, 0, 1'b0};
        vecs[10] = '{3'b010, 1'b0, 1, 0, 1, 1'b0};
        vecs[11] = '{3'b011, 1'b0, 1, 0, 2, 1'b0};
        vecs[12] = '{3'b001, 1'b0, 0, 1, 1, 1'b0};

        reset_n = 1'b0;
        tick(3);
        check("reset_running", int'(running), 0);
        check("reset_count", int'(step_count), 0);
        check("reset_fwd", int'(step_fwd), 0);
        check("reset_back", int'(step_back), 0);
        reset_n = 1'b1;
        tick(2);

        for (int i = 0; i < 13; i++) begin
            f0 = n_fwd;
            b0 = n_back;
            sort_done = vecs[i].sd;
            press(vecs[i].btn);
            check($sformatf("vec%0d_fwd", i), n_fwd - f0, vecs[i].d_fwd);
            check($sformatf("vec%0d_back", i), n_back - b0, vecs[i].d_back);
            check($sformatf("vec%0d_count", i), int'(step_count), vecs[i].cnt);
            check($sformatf("vec%0d_running", i), int'(running), int'(vecs[i].run));
        end
        sort_done = 1'b0;

        // Clean press latency: count 1 -> 2
        btnR = 1'b1;
        wait_fwd(12, t);
        check("latency_r", t, 7);
        tick(1);
        check("latency_r_count", int'(step_count), 2);
        check("latency_r_single", int'(step_fwd), 0);
        btnR = 1'b0;
        tick(10);

        // Bouncing button: count 2 -> 3
        f0 = n_fwd;
        for (int i = 0; i < 10; i++) begin
            btnR = (i % 2 == 0);
            tick(2);
        end
        check("bounce_quiet", n_fwd - f0, 0);
        btnR = 1'b1;
        wait_fwd(12, t);
        check("bounce_latency", t, 7);
        tick(6);
        check("bounce_one_pulse", n_fwd - f0, 1);
        btnR = 1'b0;
        tick(10);

        // Auto-run: three steps, count 3 -> 6
        btnC = 1'b1;
        wait_running(1'b1, 12, t);
        check("run_latency", t, 7);
        btnC = 1'b0;
        np = 0;
        p = '{-1, -1, -1};
        for (int k = 1; k <= 35; k++) begin
            tick(1);
            if (step_fwd) begin
                if (np < 3) p[np] = k;
                np++;
            end
        end
        check("run_pulses", np, 3);
        check("run_p0", p[0], 10);
        check("run_p1", p[1], 20);
        check("run_p2", p[2], 30);
        check("run_count", int'(step_count), 6);

        sort_done = 1'b1;
        tick(1);
        check("done_running", int'(running), 0);
        f0 = n_fwd;
        tick(20);
        press(3'b100);
        tick(10);
        check("done_no_steps", n_fwd - f0, 0);
        check("done_btnc_ignored", int'(running), 0);
        b0 = n_back;
        press(3'b001);
        check("done_btnl_back", n_back - b0, 1);
        check("done_btnl_count", int'(step_count), 5);
        sort_done = 1'b0;
        f0 = n_fwd;
        press(3'b010);
        check("paused_after_done", n_fwd - f0, 1);
        check("paused_after_done_count", int'(step_count), 6);

        // C and R together: C wins, no extra step
        f0 = n_fwd;
        {btnC, btnR} = 2'b11;
        wait_running(1'b1, 12, t);
        check("cr_run_latency", t, 7);
        {btnC, btnR} = 2'b00;
        tick(8);
        check("cr_no_extra_fwd", n_fwd - f0, 0);
        btnC = 1'b1;
        wait_running(1'b0, 12, t);
        check("pause_latency", t, 7);
        btnC = 1'b0;
        check("pause_count", int'(step_count), 7);
        tick(10);

        // Saturation: 7 -> 15, then auto-pause
        btnC = 1'b1;
        wait_running(1'b1, 12, t);
        btnC = 1'b0;
        wait_running(1'b0, 200, t);
        check("sat_paused", int'(t > 0), 1);
        check("sat_count", int'(step_count), 15);
        f0 = n_fwd;
        tick(20);
        press(3'b010);
        check("sat_btnr_ignored", n_fwd - f0, 0);
        check("sat_count_hold", int'(step_count), 15);

        // Reset while running at count 5
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        btnC = 1'b1;
        wait_running(1'b1, 12, t);
        btnC = 1'b0;
        t = -1;
        for (int k = 1; k <= 80; k++) begin
            tick(1);
            if (step_count == 4'd5) begin
                t = k;
                break;
            end
        end
        check("rst_reach5", int'(t > 0 && running), 1);
        reset_n = 1'b0;
        tick(1);
        check("rst_running", int'(running), 0);
        check("rst_count", int'(step_count), 0);
        check("rst_fwd", int'(step_fwd), 0);
        check("rst_back", int'(step_back), 0);
        reset_n = 1'b1;
        tick(2);

        // Button held through reset produces nothing until re-pressed
        f0 = n_fwd;
        btnR = 1'b1;
        tick(3);
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(20);
        check("held_no_pulse", n_fwd - f0, 0);
        btnR = 1'b0;
        tick(10);
        press(3'b010);
        check("held_repress", n_fwd - f0, 1);
        check("held_repress_count", int'(step_count), 1);

        check("fwd_back_exclusive", n_both, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
